// File: rtl/pmod_scanner.sv
// Knight-rider style scanner for an 8-LED PMOD: a bouncing or wrapping lit position
// with a decaying PWM trail behind it, paced by a prescaled step tick.
module pmod_scanner #(
  parameter int TICK_DIV    = 750000,
  parameter int DECAY_SHIFT = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       WRAP,
  output logic [7:0] LED_N,
  output logic       SYNC
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {FWD = 1'b0, REV = 1'b1} state_t;

  logic [PW-1:0] r_presc;
  logic [7:0]    r_pwm;
  logic [2:0]    r_pos;
  state_t        r_state;
  logic [7:0]    r_bright [8];
  logic [2:0]    w_pos_nxt;
  state_t        w_state_nxt;
  logic [7:0]    w_bright_nxt [8];
  logic [7:0]    w_led_nxt;
  logic          w_sync_nxt;
  logic          w_tick;

  // A tick needs EN in the same cycle, so a tick coinciding with EN falling is dropped.
  assign w_tick = EN && (r_presc == PRESC_MAX);

  // Step prescaler (frozen while paused) and free-running PWM counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_presc <= '0;
      r_pwm   <= 8'd0;
    end else begin
      r_pwm <= r_pwm + 8'd1;
      if (!EN) begin
        r_presc <= r_presc;
      end else if (w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Scan state register: direction, position and per-channel brightness
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= FWD;
      r_pos   <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        r_bright[i] <= (i == 0) ? 8'd255 : 8'd0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      for (int i = 0; i < 8; i++) begin
        r_bright[i] <= w_bright_nxt[i];
      end
    end
  end

  // Next direction/position on tick; brightness refresh uses pre-tick values
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    if (w_tick) begin
      case (r_state)
        FWD: begin
          if (r_pos == 3'd7) begin
            if (WRAP) begin
              w_pos_nxt = 3'd0;
            end else begin
              w_pos_nxt   = 3'd6;
              w_state_nxt = REV;
            end
          end else begin
            w_pos_nxt = r_pos + 3'd1;
          end
        end
        REV: begin
          if (r_pos == 3'd0) begin
            w_pos_nxt   = 3'd1;
            w_state_nxt = FWD;
          end else if (WRAP) begin
            w_pos_nxt   = r_pos + 3'd1;
            w_state_nxt = FWD;
          end else begin
            w_pos_nxt = r_pos - 3'd1;
          end
        end
        default: begin
          w_pos_nxt   = 3'd0;
          w_state_nxt = FWD;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
      w_pos_nxt   = r_pos;
    end
    for (int i = 0; i < 8; i++) begin
      if (w_tick) begin
        w_bright_nxt[i] = (w_pos_nxt == 3'(i)) ? 8'd255 : (r_bright[i] >> DECAY_SHIFT);
      end else begin
        w_bright_nxt[i] = r_bright[i];
      end
    end
  end

  // Output decode: PWM compare per channel and position-zero marker
  always_comb begin
    w_led_nxt = 8'd0;
    for (int i = 0; i < 8; i++) begin
      w_led_nxt[i] = ~(r_pwm < r_bright[i]);
    end
    w_sync_nxt = w_tick && (w_pos_nxt == 3'd0);
  end

  // Registered pin drivers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LED_N <= 8'hFF;
      SYNC  <= 1'b0;
    end else begin
      LED_N <= w_led_nxt;
      SYNC  <= w_sync_nxt;
    end
  end

endmodule

// File: tb/tb_pmod_scanner.sv
// Directed bench for pmod_scanner with TICK_DIV=4, DECAY_SHIFT=1.
module tb_pmod_scanner;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic       WRAP;
  logic [7:0] LED_N;
  logic       SYNC;

  int n_cmp;
  int n_err;

  pmod_scanner #(.TICK_DIV(4), .DECAY_SHIFT(1)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .EN   (EN),
    .WRAP (WRAP),
    .LED_N(LED_N),
    .SYNC (SYNC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Reset held over two falling edges; the next rising edge is the first with RST_N=1.
  task automatic do_reset(input logic wrap_v);
    @(negedge CLK);
    RST_N = 1'b0;
    EN    = 1'b1;
    WRAP  = wrap_v;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    step(6);
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if (LED_N !== 8'hFF) begin n_err++; $display("FAIL reset_led got=%h exp=ff", LED_N); end
    n_cmp++;
    if (SYNC !== 1'b0) begin n_err++; $display("FAIL reset_sync got=%b exp=0", SYNC); end
    n_cmp++;
    if (dut.r_pos !== 3'd0) begin n_err++; $display("FAIL reset_pos got=%0d exp=0", dut.r_pos); end
    @(negedge CLK);
    RST_N = 1'b1;
    step(1);
    n_cmp++;
    if (LED_N !== 8'hFE) begin n_err++; $display("FAIL reset_first_led got=%h exp=fe", LED_N); end
  endtask

  task automatic test_bounce();
    logic [2:0] exp_pos [14];
    int syncs;
    exp_pos = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    syncs = 0;
    do_reset(1'b0);
    for (int c = 1; c <= 56; c++) begin
      step(1);
      if (SYNC === 1'b1) syncs++;
      if (c % 4 == 0) begin
        n_cmp++;
        if (dut.r_pos !== exp_pos[c/4 - 1]) begin
          n_err++; $display("FAIL bounce_pos tick=%0d got=%0d exp=%0d", c/4, dut.r_pos, exp_pos[c/4 - 1]);
        end
      end
      if (c == 28) begin
        n_cmp++;
        if (dut.r_state !== 1'b0) begin n_err++; $display("FAIL bounce_state7 got=%b exp=0", dut.r_state); end
      end
      if (c == 32) begin
        n_cmp++;
        if (dut.r_state !== 1'b1) begin n_err++; $display("FAIL bounce_state8 got=%b exp=1", dut.r_state); end
      end
    end
    n_cmp++;
    if (SYNC !== 1'b1) begin n_err++; $display("FAIL bounce_sync_last got=%b exp=1", SYNC); end
    n_cmp++;
    if (syncs != 1) begin n_err++; $display("FAIL bounce_sync_count got=%0d exp=1", syncs); end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_pos [9];
    int syncs;
    exp_pos = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    syncs = 0;
    do_reset(1'b1);
    for (int c = 1; c <= 36; c++) begin
      step(1);
      if (SYNC === 1'b1) syncs++;
      if (c % 4 == 0) begin
        n_cmp++;
        if (dut.r_pos !== exp_pos[c/4 - 1]) begin
          n_err++; $display("FAIL wrap_pos tick=%0d got=%0d exp=%0d", c/4, dut.r_pos, exp_pos[c/4 - 1]);
        end
      end
      if (c == 32) begin
        n_cmp++;
        if (SYNC !== 1'b1) begin n_err++; $display("FAIL wrap_sync_t8 got=%b exp=1", SYNC); end
      end
    end
    n_cmp++;
    if (syncs != 1) begin n_err++; $display("FAIL wrap_sync_count got=%0d exp=1", syncs); end
    n_cmp++;
    if (dut.r_state !== 1'b0) begin n_err++; $display("FAIL wrap_state got=%b exp=0", dut.r_state); end
  endtask

  task automatic test_brightness();
    int lit [8];
    int exp_lit [8];
    exp_lit = '{31, 63, 127, 255, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) lit[i] = 0;
    do_reset(1'b0);
    step(12);
    EN = 1'b0;
    for (int c = 0; c < 256; c++) begin
      step(1);
      for (int i = 0; i < 8; i++) begin
        if (LED_N[i] === 1'b0) lit[i]++;
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (lit[i] != exp_lit[i]) begin
        n_err++; $display("FAIL bright_lit ch=%0d got=%0d exp=%0d", i, lit[i], exp_lit[i]);
      end
    end
    n_cmp++;
    if (dut.r_pos !== 3'd3) begin n_err++; $display("FAIL bright_pos got=%0d exp=3", dut.r_pos); end
    EN = 1'b1;
  endtask

  task automatic test_pause();
    do_reset(1'b0);
    step(6);
    EN = 1'b0;
    step(20);
    n_cmp++;
    if (dut.r_pos !== 3'd1) begin n_err++; $display("FAIL pause_pos got=%0d exp=1", dut.r_pos); end
    n_cmp++;
    if (dut.r_pwm !== 8'd26) begin n_err++; $display("FAIL pause_pwm got=%0d exp=26", dut.r_pwm); end
    n_cmp++;
    if (dut.r_presc !== 2'd2) begin n_err++; $display("FAIL pause_presc got=%0d exp=2", dut.r_presc); end
    EN = 1'b1;
    step(1);
    n_cmp++;
    if (dut.r_pos !== 3'd1) begin n_err++; $display("FAIL pause_resume1 got=%0d exp=1", dut.r_pos); end
    step(1);
    n_cmp++;
    if (dut.r_pos !== 3'd2) begin n_err++; $display("FAIL pause_resume2 got=%0d exp=2", dut.r_pos); end
  endtask

  task automatic test_rev_wrap();
    do_reset(1'b0);
    step(32);
    n_cmp++;
    if (dut.r_pos !== 3'd6 || dut.r_state !== 1'b1) begin
      n_err++; $display("FAIL rev_setup got=%0d/%b exp=6/1", dut.r_pos, dut.r_state);
    end
    // WRAP raised between ticks only; must be ignored
    WRAP = 1'b1;
    step(2);
    WRAP = 1'b0;
    step(2);
    n_cmp++;
    if (dut.r_pos !== 3'd5 || dut.r_state !== 1'b1) begin
      n_err++; $display("FAIL rev_wrap_glitch got=%0d/%b exp=5/1", dut.r_pos, dut.r_state);
    end
    WRAP = 1'b1;
    step(4);
    n_cmp++;
    if (dut.r_pos !== 3'd6 || dut.r_state !== 1'b0) begin
      n_err++; $display("FAIL rev_wrap_turn got=%0d/%b exp=6/0", dut.r_pos, dut.r_state);
    end
    step(2);
    #2;
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if (LED_N !== 8'hFF) begin n_err++; $display("FAIL rev_async_led got=%h exp=ff", LED_N); end
    n_cmp++;
    if (dut.r_pos !== 3'd0 || dut.r_state !== 1'b0) begin
      n_err++; $display("FAIL rev_async_pos got=%0d/%b exp=0/0", dut.r_pos, dut.r_state);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    WRAP  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RST_N = 1'b0;
    EN    = 1'b0;
    WRAP  = 1'b0;
    test_reset();
    test_bounce();
    test_wrap();
    test_brightness();
    test_pause();
    test_rev_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pmod_scanner.md
PMOD_SCANNER -- requirements
Module: pmod_scanner

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 750000, clock cycles per scan step (minimum 2).
REQ-002 The block SHALL have parameter DECAY_SHIFT, default 1, right-shift applied to non-active channel brightness per step (1..7).
REQ-003 The block SHALL have port CLK, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port EN, input, 1, where 1 runs the scan and 0 pauses it.
REQ-006 The block SHALL have port WRAP, input, 1, where 0 selects bounce mode and 1 selects wrap mode.
REQ-007 The block SHALL have port LED_N, output, 8, active-low PMOD LED drive; bit i is channel i (D0..D7).
REQ-008 The block SHALL have port SYNC, output, 1, a one-cycle pulse each time the scan position becomes 0.

Function
REQ-009 The prescaler SHALL count 0..TICK_DIV-1 while EN=1, and SHALL assert internal tick for exactly the cycle it holds TICK_DIV-1, then return to 0.
REQ-010 While EN=0, the prescaler SHALL hold its value and tick SHALL be 0; a tick coinciding with EN falling is suppressed.
REQ-011 The PWM counter SHALL be 8 bits, increment every cycle regardless of EN, and wrap 255->0.
REQ-012 The block SHALL keep an 8-bit brightness register per channel (bright[0..7]) and a 3-bit position pos.
REQ-013 The direction FSM SHALL have states FWD and REV; it SHALL change state and pos only on tick.
REQ-014 In FWD with pos<7, a tick SHALL increment pos.
REQ-015 In FWD with pos=7, a tick SHALL set pos to 6 and the state to REV when WRAP=0, and SHALL set pos to 0 with the state staying FWD when WRAP=1.
REQ-016 In REV with pos>0, a tick SHALL decrement pos when WRAP=0; if WRAP=1, the tick SHALL set the state to FWD and increment pos (7 wraps to 0).
REQ-017 In REV with pos=0, a tick SHALL set pos to 1 and the state to FWD.
REQ-018 WRAP SHALL be sampled only on tick cycles; WRAP changes between ticks have no effect.
REQ-019 On tick, bright[new pos] SHALL be loaded with 255, and every other channel SHALL be loaded with bright >> DECAY_SHIFT using its pre-tick value (logical shift, zero-filled).
REQ-020 LED_N[i] SHALL be registered: LED_N[i] <= ~(pwm_cnt < bright[i]), one cycle of latency from pwm_cnt/bright to the pin.
REQ-021 As a consequence of REQ-020, bright=0 SHALL be never lit and bright=255 SHALL be lit 255 of every 256 cycles.
REQ-022 SYNC SHALL be registered and high for the one cycle after a tick whose new pos is 0; it SHALL be low otherwise.
REQ-023 While EN=0, the block SHALL hold bright, pos and the FSM state, while PWM and LED_N continue so that the frozen pattern stays visible.

Reset
REQ-024 Asserting RST_N=0 SHALL immediately set prescaler=0, pwm_cnt=0, pos=0, state=FWD, bright[0]=255, bright[1..7]=0, LED_N=8'hFF and SYNC=0.
REQ-025 Reset asserted mid-step SHALL discard the partial prescaler count; the first tick after release SHALL occur TICK_DIV cycles after the first rising edge with RST_N=1 and EN=1.
REQ-026 Reset release SHALL take effect on the first CLK rising edge with RST_N=1; no minimum pulse width beyond one cycle SHALL be required.

Verification (TICK_DIV=4, DECAY_SHIFT=1 unless stated)
REQ-027 Scenario: reset, hold EN=1, WRAP=0 for 14 ticks -> pos sequence 1,2,3,4,5,6,7,6,5,4,3,2,1,0; SYNC pulses once, after tick 14.
REQ-028 Scenario: WRAP=1, 9 ticks from reset -> pos 1..7,0,1; SYNC pulses after tick 8.
REQ-029 Scenario: after 3 ticks from reset (pos=3) -> bright = {ch0:31, ch1:63, ch2:127, ch3:255, others 0}; over 256 cycles LED_N[3] is low for 255 cycles, LED_N[2] for 127, LED_N[4] for 0.
REQ-030 Scenario: drop EN for 20 cycles mid-step with prescaler=2 -> pos and bright unchanged and PWM keeps running; after EN rises, the next tick arrives 2 cycles later.
REQ-031 Scenario: in REV at pos=5, set WRAP=1 -> next tick gives state FWD and pos=6; reassert RST_N=0 mid-step -> LED_N=8'hFF and pos=0 without waiting for a clock edge.
